// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan driver: frame layout and FSM states.
package seg_pkg;

  localparam int SEG_W        = 7;
  localparam int N_DIGITS_DEF = 2;

  typedef logic [N_DIGITS_DEF-1:0][SEG_W-1:0] seg_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Digit dwell counter (div) and digit index (idx) for the scan; flags the last
// cycle of a frame so the display register can swap without tearing.
module seg_scan_timer #(
  parameter int N_DIGITS    = 2,
  parameter int REFRESH_DIV = 4,
  parameter int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  parameter int DIV_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [IDX_W-1:0] idx,
  output logic [DIV_W-1:0] div,
  output logic             frame_end
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      div <= '0;
    end else if (run) begin
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign frame_end = run && (div == DIV_LAST) && (idx == IDX_LAST);

endmodule

// File: rtl/seg_scan_drive.sv
// Multiplexed seven-segment driver: double-buffered frames (pend -> disp) that
// swap only at frame boundaries, one dead cycle per digit dwell, registered blank.
module seg_scan_drive #(
  parameter int N_DIGITS    = 2,
  parameter int SEG_W       = 7,
  parameter int REFRESH_DIV = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [N_DIGITS-1:0][SEG_W-1:0]   s_data,
  input  logic                             blank,
  output logic [N_DIGITS-1:0]              an,
  output logic [SEG_W-1:0]                 seg
);

  import seg_pkg::*;

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);

  state_t                         state;
  logic [N_DIGITS-1:0][SEG_W-1:0] pend;
  logic [N_DIGITS-1:0][SEG_W-1:0] disp;
  logic                           pend_valid;
  logic                           blank_q;
  logic [IDX_W-1:0]               idx;
  logic [DIV_W-1:0]               div;
  logic                           frame_end;
  logic                           accept;

  // Valid/ready: a frame transfers on any rising edge where s_valid && s_ready;
  // s_ready is high exactly when the pending slot is empty, and the producer
  // must hold s_data stable while s_valid is high and s_ready is low.
  assign s_ready = !pend_valid;
  assign accept  = s_valid && s_ready;

  seg_scan_timer #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .IDX_W       (IDX_W),
    .DIV_W       (DIV_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state == SCAN),
    .idx       (idx),
    .div       (div),
    .frame_end (frame_end)
  );

  // The pending slot is only cleared when full and only loaded when empty,
  // so the consume and accept updates below never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      pend_valid <= 1'b0;
      disp       <= '0;
      blank_q    <= 1'b0;
    end else begin
      blank_q <= blank;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            disp       <= pend;
            pend_valid <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (frame_end && pend_valid) begin
            disp       <= pend;
            pend_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        pend       <= s_data;
        pend_valid <= 1'b1;
      end
    end
  end

  // Decode from registers only; div==0 is the dead cycle between digits.
  always_comb begin
    an  = '0;
    seg = '0;
    if (state == SCAN && div != '0 && !blank_q) begin
      an[idx] = 1'b1;
      seg     = disp[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_drive.sv
// Directed bench for seg_scan_drive (N_DIGITS=2, REFRESH_DIV=4) with a
// queue-based scoreboard checked by an independent monitor.
module tb_seg_scan_drive;

  localparam int ND = 2;
  localparam int SW = 7;
  localparam int EW = ND + SW + 1;

  logic                   clk;
  logic                   rst;
  logic                   s_valid;
  logic                   s_ready;
  logic [ND-1:0][SW-1:0]  s_data;
  logic                   blank;
  logic [ND-1:0]          an;
  logic [SW-1:0]          seg;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            errors;
  int            ph;
  event          mid_sample;

  logic [ND-1:0] tab_an [8];
  logic [ND-1:0][SW-1:0] frm_a, frm_b, frm_c;

  seg_scan_drive #(
    .N_DIGITS    (ND),
    .SEG_W       (SW),
    .REFRESH_DIV (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .blank   (blank),
    .an      (an),
    .seg     (seg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor: pops one expectation per sample point and compares
  initial begin
    logic [EW-1:0] e;
    string         nm;
    forever begin
      @(negedge clk or mid_sample);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({an, seg, s_ready} !== e) begin
          errors++;
          $display("FAIL %s: an=%b seg=%h s_ready=%b, required an=%b seg=%h s_ready=%b",
                   nm, an, seg, s_ready, e[EW-1 -: ND], e[SW:1], e[0]);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [ND-1:0] a, input logic [SW-1:0] s,
                      input logic r);
    exp_q.push_back({a, s, r});
    name_q.push_back(nm);
  endtask

  task automatic tick_exp(input string nm, input logic [ND-1:0] a, input logic [SW-1:0] s,
                          input logic r);
    @(posedge clk);
    #1;
    push(nm, a, s, r);
  endtask

  // advance one scan cycle; lo/hi are the patterns expected on digit 0 / digit 1
  task automatic scan_tick(input string nm, input logic [SW-1:0] lo, input logic [SW-1:0] hi,
                           input logic r, input logic dark);
    logic [ND-1:0] a;
    logic [SW-1:0] s;
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
    a  = dark ? '0 : tab_an[ph];
    s  = (a == 2'b01) ? lo : (a == 2'b10) ? hi : '0;
    push(nm, a, s, r);
  endtask

  // driver
  initial begin
    checks = 0;
    errors = 0;
    ph     = 0;
    tab_an[0] = 2'b00; tab_an[1] = 2'b01; tab_an[2] = 2'b01; tab_an[3] = 2'b01;
    tab_an[4] = 2'b00; tab_an[5] = 2'b10; tab_an[6] = 2'b10; tab_an[7] = 2'b10;
    frm_a = {7'h06, 7'h3F};
    frm_b = {7'h5B, 7'h4F};
    frm_c = {7'h66, 7'h6D};
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    blank   = 1'b0;

    // reset and idle
    tick_exp("rst_hold0", 2'b00, 7'h00, 1'b1);
    tick_exp("rst_hold1", 2'b00, 7'h00, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick_exp("idle", 2'b00, 7'h00, 1'b1);

    // single frame A accepted at E0
    s_valid = 1'b1;
    s_data  = frm_a;
    tick_exp("a_accept", 2'b00, 7'h00, 1'b0);
    s_valid = 1'b0;
    tick_exp("a_load", 2'b00, 7'h00, 1'b1);
    ph = 0;
    for (int i = 0; i < 15; i++) scan_tick("a_scan", 7'h3F, 7'h06, 1'b1, 1'b0);

    // B accepted mid-frame (idx=1); C held until B moves to disp
    for (int i = 0; i < 6; i++) scan_tick("a_scan2", 7'h3F, 7'h06, 1'b1, 1'b0);
    s_valid = 1'b1;
    s_data  = frm_b;
    scan_tick("b_pend", 7'h3F, 7'h06, 1'b0, 1'b0);
    s_data = frm_c;
    scan_tick("a_finish", 7'h3F, 7'h06, 1'b0, 1'b0);
    scan_tick("b_swap", 7'h4F, 7'h5B, 1'b1, 1'b0);
    scan_tick("c_accept", 7'h4F, 7'h5B, 1'b0, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) scan_tick("b_scan", 7'h4F, 7'h5B, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) scan_tick("c_scan", 7'h6D, 7'h66, 1'b1, 1'b0);

    // A accepted on a boundary edge with pend empty: pend only, shown next frame
    s_valid = 1'b1;
    s_data  = frm_a;
    scan_tick("bnd_accept", 7'h6D, 7'h66, 1'b0, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 7; i++) scan_tick("bnd_hold", 7'h6D, 7'h66, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) scan_tick("bnd_show", 7'h3F, 7'h06, 1'b1, 1'b0);

    // blank for 10 cycles; counters keep running underneath
    blank = 1'b1;
    for (int i = 0; i < 10; i++) scan_tick("blank_on", 7'h3F, 7'h06, 1'b1, 1'b1);
    blank = 1'b0;
    for (int i = 0; i < 3; i++) scan_tick("blank_off", 7'h3F, 7'h06, 1'b1, 1'b0);

    // load B into pend while digit 1 lit, then reset mid-cycle
    s_valid = 1'b1;
    s_data  = frm_b;
    scan_tick("pre_rst", 7'h3F, 7'h06, 1'b0, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("rst_async", 2'b00, 7'h00, 1'b1);
    -> mid_sample;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick_exp("post_rst_dark", 2'b00, 7'h00, 1'b1);

    // new frame after reset restarts from IDLE
    s_valid = 1'b1;
    s_data  = frm_c;
    tick_exp("c2_accept", 2'b00, 7'h00, 1'b0);
    s_valid = 1'b0;
    tick_exp("c2_load", 2'b00, 7'h00, 1'b1);
    ph = 0;
    for (int i = 0; i < 8; i++) scan_tick("c2_scan", 7'h6D, 7'h66, 1'b1, 1'b0);

    // drain: every expectation must have been consumed
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
